control_multiciclo: RTL and testbench
=====================================

// Module: control_multiciclo
// PURPOSE
//  Main control FSM for the multicycle variant of the processor. It sequences the shared ALU,
//  memory port, IR, PC and register file over several cycles per instruction.
//  It drives ALUop into controlALU: 00=add, 01=sub, 10=use funct field.
//  It waits on a memory ready handshake and bounds every wait with a timeout.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles spent waiting on mem_ready in a memory state before timeout
//  CNT_W         4   width of the wait counter (2**CNT_W > MEM_WAIT_MAX)
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  reset        in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26]; sampled in DECODE
//  mem_ready    in   1  memory completes the current access in this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU zero (beq)
//  IorD         out  1  memory address: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load instruction register
//  MemtoReg     out  1  register write data: 0=ALUOut, 1=MDR
//  RegDst       out  1  destination register: 0=rt, 1=rd
//  RegWrite     out  1  register file write
//  ALUSrcA      out  1  0=PC, 1=reg A
//  ALUSrcB      out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
//  ALUop        out  2  to controlALU
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  estado       out  4  current state encoding (debug)
//  instr_done   out  1  1-cycle pulse in an instruction's last cycle
//  illegal_op   out  1  1-cycle pulse: unknown opcode in DECODE
//  mem_timeout  out  1  1-cycle pulse: wait exceeded MEM_WAIT_MAX
// BEHAVIOUR
//  States (estado): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7,
//   BRANCH=8, JUMP=9; codes 10-15 are unreachable and go to FETCH next cycle.
//  While reset=1 all outputs are 0. The edge with reset=1 sets state=FETCH and wait counter=0.
//   Reset asserted mid-instruction aborts it with no further writes.
//  Unlisted outputs are 0 in each state. Outputs are Moore, except the gated strobes noted below.
//  FETCH:  MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
//   IRWrite and PCWrite = mem_ready (only in the completing cycle). mem_ready=1 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opcode:
//   000000 -> EXEC; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP;
//   any other opcode -> FETCH with illegal_op=1.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MEMRD; sw -> MEMWR.
//  MEMRD:  MemRead=1, IorD=1. mem_ready=1 -> MEMWB.
//  MEMWB:  RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
//  MEMWR:  MemWrite=1, IorD=1. instr_done = mem_ready. mem_ready=1 -> FETCH.
//  EXEC:   ALUSrcA=1, ALUSrcB=00, ALUop=10 -> RWB.
//  RWB:    RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
//  JUMP:   PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
//  The decoded lw/sw class is registered in DECODE. MEMADR does not resample opcode.
//  Wait counter rules (FETCH, MEMRD, MEMWR):
//   - Counts cycles with mem_ready=0; clears on any state change.
//   - Count reaching MEM_WAIT_MAX with mem_ready still 0 -> mem_timeout=1 that cycle, next FETCH.
//     No IRWrite, PCWrite, MemWrite-completion or RegWrite is issued for the aborted access.
//   - mem_ready=1 in the same cycle as the limit: completion wins and there is no timeout.
//  Latency with mem_ready tied 1 (cycles incl. FETCH): R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
// TESTING
//  1. mem_ready=1, opcode=000000 -> estado 0,1,6,7,0. ALUop=10 in EXEC. RegWrite=RegDst=1 in RWB.
//     instr_done at cycle 4.
//  2. lw (100011), mem_ready=1 -> estado 0,1,2,3,4. MemtoReg=RegWrite=1 in MEMWB.
//     ALUSrcB=10 in MEMADR.
//  3. sw (101011), mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, instr_done only on
//     the ready cycle, then FETCH.
//  4. beq (000100) -> ALUop=01, PCWriteCond=1, PCSource=01 in BRANCH. j (000010) ->
//     PCWrite=1, PCSource=10.
//  5. mem_ready=0 for 15 cycles in FETCH (MEM_WAIT_MAX=15) -> mem_timeout pulse, IRWrite never 1.
//     Repeat with ready on cycle 15 -> DECODE, no timeout.
//  6. opcode=111111 -> illegal_op in DECODE, back to FETCH. Reset in MEMRD -> outputs 0,
//     then estado=0.

Source files
------------

// File: rtl/control_multiciclo.sv
// Main control FSM of the multicycle processor.
// Sequences the shared ALU, memory port, IR, PC and register file over several
// cycles per instruction. Every memory wait (FETCH, MEMRD, MEMWR) is bounded by
// a counter; when the bound expires the access is abandoned and FETCH restarts.
//
// Handshake: mem_ready is a completion strobe from memory. An access in a wait
// state completes in the cycle where mem_ready=1; only that cycle issues the
// completion side effects (IRWrite/PCWrite in FETCH, instr_done in MEMWR) and
// moves the FSM on. Request outputs (MemRead/MemWrite) are held level for the
// whole time the FSM sits in the wait state.
module control_multiciclo #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] estado,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Counter value seen in the last allowed waiting cycle: one more idle cycle
  // would make the count reach MEM_WAIT_MAX.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_store;   // lw/sw class captured in DECODE
  logic             wait_state;
  logic             timeout;

  assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Completion has priority: a ready in the limit cycle is never a timeout.
  assign timeout    = wait_state && !mem_ready && (wait_cnt >= WAIT_LAST);

  // Next-state selection from current state, opcode (DECODE only) and mem_ready.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_EXEC;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_RWB:    next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // State, wait counter and lw/sw class register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      if (!wait_state || mem_ready || timeout || (next_state != state)) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == S_DECODE) begin
        is_store <= (opcode == OP_SW);
      end
    end
  end

  // Moore decode of the state; FETCH/MEMWR strobes gated by mem_ready; all 0 in reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    estado      = 4'd0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      estado      = state;
      mem_timeout = timeout;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          illegal_op = (next_state == S_FETCH);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUop   = 2'b10;
        end
        S_RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUop       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: begin
          estado = state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Testbench for control_multiciclo: scenario tasks walk each instruction class
// through its expected state path, build the expected output vector for every
// cycle from the control table, queue it, and a negedge monitor compares.
module tb_control_multiciclo;

  localparam int W       = 23;
  localparam int WAITMAX = 15;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] estado;
  logic       instr_done, illegal_op, mem_timeout;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  control_multiciclo #(.MEM_WAIT_MAX(WAITMAX), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .estado(estado), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs from the control table, packed in the same order as the monitor.
  function automatic logic [W-1:0] exp_out(input logic rst, input logic [3:0] st,
                                          input logic [5:0] op, input logic rdy,
                                          input logic tmo);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!rst) begin
      case (st)
        4'd0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
        4'd1: begin
          asb = 2'b11;
          ill = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
        end
        4'd2: begin asa = 1; asb = 2'b10; end
        4'd3: begin mr = 1; iord = 1; end
        4'd4: begin rw = 1; m2r = 1; done = 1; end
        4'd5: begin mw = 1; iord = 1; done = rdy; end
        4'd6: begin asa = 1; aop = 2'b10; end
        4'd7: begin rw = 1; rdst = 1; done = 1; end
        4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
        4'd9: begin pcw = 1; pcs = 2'b10; done = 1; end
        default: ;
      endcase
    end
    return {(rst ? 4'd0 : st), pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
            asb, aop, pcs, done, ill, (rst ? 1'b0 : tmo)};
  endfunction

  // Driver: one cycle of stimulus, expectation queued for the negedge monitor.
  task automatic cycle(input string tag, input logic rst, input logic [3:0] st,
                       input logic [5:0] op, input logic rdy, input logic tmo);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(exp_out(rst, st, op, rdy, tmo));
    tag_q.push_back(tag);
  endtask

  // Cycles in a state whose outputs ignore opcode/mem_ready: both randomised.
  task automatic plain(input string tag, input logic [3:0] st);
    cycle(tag, 1'b0, st, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // A wait state: n_low idle cycles then ready, or the full bound then timeout.
  task automatic wait_phase(input string tag, input logic [3:0] st, input int n_low,
                            input bit to);
    if (to) begin
      for (int i = 0; i < WAITMAX - 1; i++)
        cycle(tag, 1'b0, st, 6'($urandom_range(0, 63)), 1'b0, 1'b0);
      cycle({tag, "_timeout"}, 1'b0, st, 6'($urandom_range(0, 63)), 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n_low; i++)
        cycle(tag, 1'b0, st, 6'($urandom_range(0, 63)), 1'b0, 1'b0);
      cycle({tag, "_ready"}, 1'b0, st, 6'($urandom_range(0, 63)), 1'b1, 1'b0);
    end
  endtask

  // One full instruction; mem_to aborts the data access by timeout.
  task automatic run_instr(input logic [5:0] op, input int nf, input int nm, input bit mem_to);
    wait_phase("fetch", 4'd0, nf, 1'b0);
    cycle("decode", 1'b0, 4'd1, op, 1'($urandom_range(0, 1)), 1'b0);
    case (op)
      OP_R:   begin plain("exec", 4'd6); plain("rwb", 4'd7); end
      OP_LW:  begin
        plain("memadr", 4'd2);
        wait_phase("memrd", 4'd3, nm, mem_to);
        if (!mem_to) plain("memwb", 4'd4);
      end
      OP_SW:  begin plain("memadr", 4'd2); wait_phase("memwr", 4'd5, nm, mem_to); end
      OP_BEQ: plain("branch", 4'd8);
      OP_J:   plain("jump", 4'd9);
      default: ;
    endcase
  endtask

  // Scoreboard monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(),
            {estado, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done,
             illegal_op, mem_timeout},
            exp_q.pop_front());
    end
  end

  initial begin
    logic [5:0] ops[5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};

    // Reset state: outputs all zero while reset is held.
    cycle("reset", 1'b1, 4'd0, 6'd0, 1'b1, 1'b0);
    cycle("reset", 1'b1, 4'd0, 6'd0, 1'b0, 1'b0);

    // Main instruction classes with ready tied high.
    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_LW, 0, 0, 0);
    run_instr(OP_SW, 0, 3, 0);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_J, 0, 0, 0);
    run_instr(OP_BAD, 0, 0, 0);
    run_instr(6'b001000, 2, 0, 0);

    // FETCH timeout after the full bound, then ready exactly in the limit cycle.
    wait_phase("fetch", 4'd0, 0, 1'b1);
    run_instr(OP_R, WAITMAX - 1, 0, 0);

    // Data-access timeouts and limit-cycle completion.
    run_instr(OP_LW, 0, 0, 1);
    run_instr(OP_SW, 0, 0, 1);
    run_instr(OP_LW, 1, WAITMAX - 1, 0);
    run_instr(OP_SW, 0, WAITMAX - 1, 0);

    // Reset while waiting in MEMRD aborts the load.
    wait_phase("fetch", 4'd0, 0, 1'b0);
    cycle("decode", 1'b0, 4'd1, OP_LW, 1'b1, 1'b0);
    plain("memadr", 4'd2);
    cycle("memrd", 1'b0, 4'd3, OP_LW, 1'b0, 1'b0);
    cycle("reset_memrd", 1'b1, 4'd3, OP_LW, 1'b0, 1'b0);
    cycle("after_reset", 1'b0, 4'd0, OP_LW, 1'b0, 1'b0);
    cycle("after_reset", 1'b0, 4'd0, OP_R, 1'b1, 1'b0);
    cycle("decode", 1'b0, 4'd1, OP_J, 1'b0, 1'b0);
    plain("jump", 4'd9);

    // Random instruction mix with short waits.
    for (int k = 0; k < 24; k++) begin
      run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
